// File: rtl/gb80_mem_pkg.sv
// Shared definitions for the GB80 memory bridge: DMA states, address map constants
// and the CPU address classifier.
package gb80_mem_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2
    } dma_state_t;

    typedef enum logic [1:0] {
        ACLS_EXT    = 2'd0,
        ACLS_HRAM   = 2'd1,
        ACLS_DMAREG = 2'd2
    } addr_class_t;

    localparam logic [15:0] HRAM_LO  = 16'hFF80;
    localparam logic [15:0] HRAM_HI  = 16'hFFFE;
    localparam logic [15:0] DMA_REG  = 16'hFF46;
    localparam logic [15:0] OAM_BASE = 16'hFE00;
    localparam int          DMA_LEN  = 160;

    // The DMA register wins if it is ever placed inside the HRAM window.
    function automatic addr_class_t decode_addr(input logic [15:0] addr,
                                                input logic [15:0] dma_reg);
        if (addr == dma_reg)
            return ACLS_DMAREG;
        else if (addr >= HRAM_LO && addr <= HRAM_HI)
            return ACLS_HRAM;
        else
            return ACLS_EXT;
    endfunction

endpackage

// File: rtl/gb80_dma_engine.sv
// OAM DMA engine: copies DMA_LEN bytes from {src, idx} to OAM_BASE + idx,
// one byte every two cycles, restartable from any state.
//
// state  | meaning
// S_IDLE | engine does not own the memory port
// S_RD   | reading source byte {src, idx} into dbyte
// S_WR   | writing dbyte to OAM_BASE + idx
module gb80_dma_engine #(
    parameter logic [15:0] OAM_BASE = gb80_mem_pkg::OAM_BASE,
    parameter int          DMA_LEN  = gb80_mem_pkg::DMA_LEN
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        i_start,
    input  logic [7:0]  i_src,
    input  logic [7:0]  i_mem_rdata,
    output logic [7:0]  o_src,
    output logic        o_active,
    output logic [15:0] o_mem_addr,
    output logic [7:0]  o_mem_wdata,
    output logic        o_mem_we,
    output logic        o_mem_re
);
    import gb80_mem_pkg::*;

    localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);

    dma_state_t r_state;
    dma_state_t w_state_nxt;
    logic [7:0] r_src;
    logic [7:0] r_idx;
    logic [7:0] r_dbyte;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_src   <= 8'h00;
            r_idx   <= 8'h00;
            r_dbyte <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            if (i_start) begin
                r_src <= i_src;
                r_idx <= 8'h00;
            end else if (r_state == S_WR && r_idx != LAST_IDX) begin
                r_idx <= r_idx + 8'd1;
            end
            if (r_state == S_RD)
                r_dbyte <= i_mem_rdata;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        o_mem_addr  = 16'h0000;
        o_mem_wdata = 8'h00;
        o_mem_we    = 1'b0;
        o_mem_re    = 1'b0;
        o_active    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start)
                    w_state_nxt = S_RD;
            end
            S_RD: begin
                o_active    = 1'b1;
                o_mem_addr  = {r_src, r_idx};
                o_mem_re    = 1'b1;
                w_state_nxt = S_WR;
            end
            S_WR: begin
                o_active    = 1'b1;
                o_mem_addr  = OAM_BASE + {8'h00, r_idx};
                o_mem_wdata = r_dbyte;
                o_mem_we    = 1'b1;
                w_state_nxt = (r_idx == LAST_IDX) ? S_IDLE : S_RD;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // A restart takes effect immediately; a WR in flight still completes this cycle.
        if (i_start)
            w_state_nxt = S_RD;
    end

    assign o_src = r_src;

endmodule

// File: rtl/gb80_mem_bridge.sv
// GB80 memory bridge: forwards CPU accesses to the memory port, hosts HRAM and the
// FF46 register, and hands the memory port to the OAM DMA engine while it runs.
module gb80_mem_bridge #(
    parameter logic [15:0] OAM_BASE = gb80_mem_pkg::OAM_BASE,
    parameter int          DMA_LEN  = gb80_mem_pkg::DMA_LEN,
    parameter logic [15:0] DMA_REG  = gb80_mem_pkg::DMA_REG
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    inout  wire  [7:0]  cpu_data,
    input  logic        cpu_we,
    input  logic        cpu_re,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic        mem_we,
    output logic        mem_re,
    output logic        dma_active
);
    import gb80_mem_pkg::*;

    addr_class_t w_cls;
    logic        w_wr;
    logic        w_rd;
    logic        w_start;
    logic [7:0]  w_src;
    logic        w_dma_active;
    logic [15:0] w_dma_addr;
    logic [7:0]  w_dma_wdata;
    logic        w_dma_we;
    logic        w_dma_re;
    logic        w_drive;
    logic [7:0]  w_rd_data;

    logic [7:0]  r_hram [0:126];

    assign w_cls   = decode_addr(cpu_addr, DMA_REG);
    assign w_wr    = cpu_we;
    assign w_rd    = cpu_re & ~cpu_we;
    assign w_start = w_wr && (w_cls == ACLS_DMAREG);

    gb80_dma_engine #(
        .OAM_BASE (OAM_BASE),
        .DMA_LEN  (DMA_LEN)
    ) u_dma (
        .clock       (clock),
        .reset       (reset),
        .i_start     (w_start),
        .i_src       (cpu_data),
        .i_mem_rdata (mem_rdata),
        .o_src       (w_src),
        .o_active    (w_dma_active),
        .o_mem_addr  (w_dma_addr),
        .o_mem_wdata (w_dma_wdata),
        .o_mem_we    (w_dma_we),
        .o_mem_re    (w_dma_re)
    );

    // HRAM deliberately has no reset.
    always_ff @(posedge clock) begin
        if (!reset && w_wr && w_cls == ACLS_HRAM)
            r_hram[cpu_addr[6:0]] <= cpu_data;
    end

    always_comb begin
        mem_addr   = 16'h0000;
        mem_wdata  = 8'h00;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        dma_active = 1'b0;
        w_drive    = 1'b0;
        w_rd_data  = 8'h00;
        if (!reset) begin
            dma_active = w_dma_active;
            if (w_dma_active) begin
                mem_addr  = w_dma_addr;
                mem_wdata = w_dma_wdata;
                mem_we    = w_dma_we;
                mem_re    = w_dma_re;
            end else if (w_cls == ACLS_EXT && (cpu_we || cpu_re)) begin
                mem_addr = cpu_addr;
                mem_we   = w_wr;
                mem_re   = w_rd;
                if (w_wr)
                    mem_wdata = cpu_data;
            end
            if (w_rd) begin
                w_drive = 1'b1;
                case (w_cls)
                    ACLS_HRAM:   w_rd_data = r_hram[cpu_addr[6:0]];
                    ACLS_DMAREG: w_rd_data = w_src;
                    default:     w_rd_data = w_dma_active ? 8'hFF : mem_rdata;
                endcase
            end
        end
    end

    assign cpu_data = w_drive ? w_rd_data : 8'hzz;

endmodule

// File: tb/tb_gb80_mem_bridge.sv
// Directed bench for gb80_mem_bridge: CPU pass-through, HRAM, FF46, full DMA,
// DMA restart and reset abort, with a byte-per-address memory model.
module tb_gb80_mem_bridge;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] cpu_addr;
    wire  [7:0]  cpu_data;
    logic        cpu_we;
    logic        cpu_re;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_we;
    logic        mem_re;
    logic        dma_active;

    logic        tb_drv;
    logic [7:0]  tb_data;

    int n_chk = 0;
    int n_err = 0;

    gb80_mem_bridge dut (
        .clock      (clock),
        .reset      (reset),
        .cpu_addr   (cpu_addr),
        .cpu_data   (cpu_data),
        .cpu_we     (cpu_we),
        .cpu_re     (cpu_re),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_we     (mem_we),
        .mem_re     (mem_re),
        .dma_active (dma_active)
    );

    assign cpu_data = tb_drv ? tb_data : 8'hzz;

    always #5 clock = ~clock;

    // byte(C0xx) = xx, byte(D0xx) = xx ^ 55, everything else = low address byte
    always_comb mem_rdata = mem_addr[7:0] ^ ((mem_addr[15:8] == 8'hD0) ? 8'h55 : 8'h00);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic cpu(input logic we, input logic re, input logic [15:0] a, input logic [7:0] d);
        cpu_we  = we;
        cpu_re  = re;
        cpu_addr = a;
        tb_data = d;
        tb_drv  = we;
        #1;
    endtask

    task automatic idle();
        cpu(1'b0, 1'b0, 16'h0000, 8'h00);
    endtask

    function automatic logic [31:0] port_now();
        return {13'h0, dma_active, mem_we, mem_re, mem_addr};
    endfunction

    function automatic logic [31:0] exp_rd(input logic [7:0] src, input int i);
        return {13'h0, 1'b1, 1'b0, 1'b1, src, 8'(i)};
    endfunction

    function automatic logic [31:0] exp_wr(input int i);
        return {13'h0, 1'b1, 1'b1, 1'b0, 16'hFE00 + 16'(i)};
    endfunction

    task automatic chk_wr(input logic [7:0] xk, input int i);
        chk("dma_wr", port_now(), exp_wr(i));
        chk("dma_wdata", 32'(mem_wdata), 32'(8'(i) ^ xk));
    endtask

    // Checks DMA bytes from..to with the CPU idle; xk is the memory-model key of src.
    task automatic run_dma(input logic [7:0] src, input logic [7:0] xk, input int from, input int to);
        for (int i = from; i <= to; i++) begin
            idle();
            chk("dma_rd", port_now(), exp_rd(src, i));
            tick();
            idle();
            chk_wr(xk, i);
            tick();
        end
    endtask

    task automatic start_dma(input logic [7:0] src);
        cpu(1'b1, 1'b0, 16'hFF46, src);
        chk("start_port", port_now(), 32'h0);
        tick();
    endtask

    initial begin
        reset = 1'b1;
        idle();
        tick();
        chk("rst_port", port_now(), 32'h0);
        chk("rst_wdata", 32'(mem_wdata), 32'h0);
        chk("rst_cpu_z", 32'(cpu_data === 8'hzz), 32'h1);
        tick();
        reset = 1'b0;
        idle();
        chk("post_rst_port", port_now(), 32'h0);
        chk("post_rst_cpu_z", 32'(cpu_data === 8'hzz), 32'h1);

        // EXT write pass-through
        cpu(1'b1, 1'b0, 16'hC000, 8'h5A);
        chk("ext_wr_port", port_now(), 32'h0002_C000);
        chk("ext_wr_data", 32'(mem_wdata), 32'h5A);
        tick();

        // EXT read pass-through
        cpu(1'b0, 1'b1, 16'hC012, 8'h00);
        chk("ext_rd_port", port_now(), 32'h0001_C012);
        chk("ext_rd_data", 32'(cpu_data), 32'h12);
        tick();

        // write and read together: treated as a write
        cpu(1'b1, 1'b1, 16'hC034, 8'h77);
        chk("wr_rd_port", port_now(), 32'h0002_C034);
        chk("wr_rd_data", 32'(mem_wdata), 32'h77);
        tick();

        // HRAM write then read, no memory-port traffic
        cpu(1'b1, 1'b0, 16'hFF90, 8'h3C);
        chk("hram_wr_port", port_now(), 32'h0);
        tick();
        cpu(1'b0, 1'b1, 16'hFF90, 8'h00);
        chk("hram_rd_port", port_now(), 32'h0);
        chk("hram_rd_data", 32'(cpu_data), 32'h3C);
        tick();
        cpu(1'b1, 1'b0, 16'hFFFE, 8'hE7);
        tick();
        cpu(1'b0, 1'b1, 16'hFFFE, 8'h00);
        chk("hram_top_data", 32'(cpu_data), 32'hE7);
        tick();

        // FF46 reads 00 after reset, FFFF is EXT
        cpu(1'b0, 1'b1, 16'hFF46, 8'h00);
        chk("dmareg_rst", 32'(cpu_data), 32'h00);
        chk("dmareg_rd_port", port_now(), 32'h0);
        tick();
        cpu(1'b0, 1'b1, 16'hFFFF, 8'h00);
        chk("ffff_ext_port", port_now(), 32'h0001_FFFF);
        tick();

        // full DMA from C0 with CPU traffic in bytes 10..13
        start_dma(8'hC0);
        run_dma(8'hC0, 8'h00, 0, 9);
        for (int i = 10; i <= 13; i++) begin
            case (i)
                10: cpu(1'b0, 1'b1, 16'h8000, 8'h00);
                11: cpu(1'b1, 1'b0, 16'h8000, 8'hAB);
                12: cpu(1'b1, 1'b0, 16'hFFA0, 8'h99);
                default: cpu(1'b0, 1'b1, 16'hFFA0, 8'h00);
            endcase
            chk("dma_cpu_rd", port_now(), exp_rd(8'hC0, i));
            if (i == 10) chk("dma_ext_rd_ff", 32'(cpu_data), 32'hFF);
            if (i == 13) chk("dma_hram_rd", 32'(cpu_data), 32'h99);
            tick();
            idle();
            chk_wr(8'h00, i);
            tick();
        end
        run_dma(8'hC0, 8'h00, 14, 159);
        idle();
        chk("dma_done_port", port_now(), 32'h0);
        cpu(1'b0, 1'b1, 16'hFF46, 8'h00);
        chk("dmareg_c0", 32'(cpu_data), 32'hC0);
        tick();

        // restart at byte 50 (WR cycle) to source D0
        start_dma(8'hC0);
        run_dma(8'hC0, 8'h00, 0, 49);
        idle();
        chk("rs_rd50", port_now(), exp_rd(8'hC0, 50));
        tick();
        cpu(1'b1, 1'b0, 16'hFF46, 8'hD0);
        chk_wr(8'h00, 50);
        tick();
        run_dma(8'hD0, 8'h55, 0, 159);
        idle();
        chk("rs_done_port", port_now(), 32'h0);
        cpu(1'b0, 1'b1, 16'hFF46, 8'h00);
        chk("dmareg_d0", 32'(cpu_data), 32'hD0);
        tick();

        // reset at byte 80 aborts the DMA
        start_dma(8'hC0);
        run_dma(8'hC0, 8'h00, 0, 79);
        idle();
        reset = 1'b1;
        #1;
        chk("abort_rst_port", port_now(), 32'h0);
        chk("abort_rst_z", 32'(cpu_data === 8'hzz), 32'h1);
        tick();
        reset = 1'b0;
        idle();
        chk("abort_idle_port", port_now(), 32'h0);
        cpu(1'b0, 1'b1, 16'hFF46, 8'h00);
        chk("abort_dmareg", 32'(cpu_data), 32'h00);
        chk("abort_rd_port", port_now(), 32'h0);
        tick();
        idle();
        chk("abort_stays_idle", port_now(), 32'h0);
        cpu(1'b0, 1'b1, 16'hFFA0, 8'h00);
        chk("hram_kept", 32'(cpu_data), 32'h99);
        tick();
        idle();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
